video_timing_gen: RTL

Parametrised successor to the fixed 640x480 raster generator. Produces VGA/DVI timing (x, y, hsync, vsync, de) for any resolution set by parameters, with programmable sync polarity and pixel-clock enable. Built-in pattern engine drives RGB: colour bars, checkerboard, gradient or solid colour. Sits between the board PLL and the pin/TMDS output stage.

---
 rtl/video_timing_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator (x/y, syncs, de) with a built-in test-pattern engine.
// Optional build macro VTG_BORDER_EN: forces a one-pixel all-ones frame around the active area.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 12,
  parameter int COLOR_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_enable,
  input  logic [1:0]             io_mode,
  input  logic [3*COLOR_W-1:0]   io_solid,
  output logic [CW-1:0]          io_ctrl_x,
  output logic [CW-1:0]          io_ctrl_y,
  output logic                   io_ctrl_hsync,
  output logic                   io_ctrl_vsync,
  output logic                   io_ctrl_de,
  output logic [COLOR_W-1:0]     io_r,
  output logic [COLOR_W-1:0]     io_g,
  output logic [COLOR_W-1:0]     io_b,
  output logic                   io_frame_start,
  output logic [15:0]            io_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  // Latched pattern selection, refreshed only when (0,0) is presented.
  logic [1:0]           mode_q;
  logic [3*COLOR_W-1:0] solid_q;

  // Bar position tracks io_ctrl_x so the bar index needs no divider.
  logic [BW-1:0]        bar_cnt_q;
  logic [2:0]           bar_idx_q;

  logic [CW-1:0]        nx, ny;
  logic                 fs_nxt;
  logic                 de_nxt;
  logic                 hs_act, vs_act;
  logic [15:0]          fc_nxt;
  logic [1:0]           mode_eff;
  logic [3*COLOR_W-1:0] solid_eff;
  logic [BW-1:0]        bar_cnt_nxt;
  logic [2:0]           bar_idx_nxt;
  logic [COLOR_W-1:0]   r_nxt, g_nxt, b_nxt;

  // Position of the pixel the next enabled cycle will present.
  always_comb begin
    nx = io_ctrl_x + CW'(1);
    ny = io_ctrl_y;
    if (io_ctrl_x == X_LAST) begin
      nx = '0;
      ny = (io_ctrl_y == Y_LAST) ? '0 : io_ctrl_y + CW'(1);
    end
  end

  always_comb begin
    fs_nxt    = (nx == '0) && (ny == '0);
    de_nxt    = (nx < H_ACT_C) && (ny < V_ACT_C);
    hs_act    = (nx >= HS_FIRST) && (nx <= HS_LAST);
    vs_act    = (ny >= VS_FIRST) && (ny <= VS_LAST);
    fc_nxt    = fs_nxt ? io_frame_count + 16'd1 : io_frame_count;
    mode_eff  = fs_nxt ? io_mode  : mode_q;
    solid_eff = fs_nxt ? io_solid : solid_q;
  end

  always_comb begin
    bar_cnt_nxt = bar_cnt_q + BW'(1);
    bar_idx_nxt = bar_idx_q;
    if (nx == '0) begin
      bar_cnt_nxt = '0;
      bar_idx_nxt = '0;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_nxt = '0;
      bar_idx_nxt = bar_idx_q + 3'd1;
    end
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
  // r = ~idx[1], g = ~idx[2], b = ~idx[0].
  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    case (mode_eff)
      2'd0: begin
        r_nxt = {COLOR_W{~bar_idx_nxt[1]}};
        g_nxt = {COLOR_W{~bar_idx_nxt[2]}};
        b_nxt = {COLOR_W{~bar_idx_nxt[0]}};
      end
      2'd1: begin
        r_nxt = {COLOR_W{nx[5] ^ ny[5]}};
        g_nxt = {COLOR_W{nx[5] ^ ny[5]}};
        b_nxt = {COLOR_W{nx[5] ^ ny[5]}};
      end
      2'd2: begin
        r_nxt = nx[COLOR_W+3:4];
        g_nxt = ny[COLOR_W+3:4];
        b_nxt = fc_nxt[COLOR_W-1:0];
      end
      default: {r_nxt, g_nxt, b_nxt} = solid_eff;
    endcase
`ifdef VTG_BORDER_EN
    if ((nx == '0) || (nx == H_ACT_C - CW'(1)) || (ny == '0) || (ny == V_ACT_C - CW'(1))) begin
      r_nxt = '1;
      g_nxt = '1;
      b_nxt = '1;
    end
`endif
    if (!de_nxt) begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_ctrl_x      <= X_LAST;
      io_ctrl_y      <= Y_LAST;
      io_ctrl_hsync  <= ~HSYNC_POL;
      io_ctrl_vsync  <= ~VSYNC_POL;
      io_ctrl_de     <= 1'b0;
      io_r           <= '0;
      io_g           <= '0;
      io_b           <= '0;
      io_frame_start <= 1'b0;
      io_frame_count <= '0;
      mode_q         <= '0;
      solid_q        <= '0;
      bar_cnt_q      <= '0;
      bar_idx_q      <= '0;
    end else if (io_enable) begin
      io_ctrl_x      <= nx;
      io_ctrl_y      <= ny;
      io_ctrl_hsync  <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      io_ctrl_vsync  <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      io_ctrl_de     <= de_nxt;
      io_r           <= r_nxt;
      io_g           <= g_nxt;
      io_b           <= b_nxt;
      io_frame_start <= fs_nxt;
      io_frame_count <= fc_nxt;
      bar_cnt_q      <= bar_cnt_nxt;
      bar_idx_q      <= bar_idx_nxt;
      if (fs_nxt) begin
        mode_q  <= io_mode;
        solid_q <= io_solid;
      end
    end else begin
      io_frame_start <= 1'b0;
    end
  end

endmodule
